// File: rtl/sram_access_sequencer_if.sv
// Request and array-drive bundle between the controller front end and the SRAM access sequencer.
// The sequencer uses the slave modport; the front end / array side uses master.
interface sram_access_sequencer_if #(
  parameter int ROWS   = 16,
  parameter int ADDR_W = 4,
  parameter int COLS   = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [COLS-1:0]   req_wdata;
  logic              precharge_en;
  logic [ROWS-1:0]   wl;
  logic              bl_drive_en;
  logic [COLS-1:0]   bl;
  logic [COLS-1:0]   blb;
  logic              sense_en;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, precharge_en, wl, bl_drive_en, bl, blb, sense_en, done, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, precharge_en, wl, bl_drive_en, bl, blb, sense_en, done, err
  );
endinterface

// File: rtl/sram_access_sequencer.sv
// Sequences one SRAM read/write through precharge, wordline-active and recovery phases.
// Array drive outputs are registered from the current phase, so they trail the state by one cycle.
module sram_access_sequencer #(
  parameter int ROWS       = 16,
  parameter int ADDR_W     = 4,
  parameter int COLS       = 8,
  parameter int PRE_CYCLES = 2,
  parameter int WL_CYCLES  = 3,
  parameter int REC_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  sram_access_sequencer_if.slave  bus
);
  localparam int MAX_AB = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int MAX_PH = (MAX_AB > REC_CYCLES) ? MAX_AB : REC_CYCLES;
  localparam int CW     = $clog2(MAX_PH) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_ACT  = 3'd2;
  localparam logic [2:0] S_REC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CW-1:0]     LAST_PRE = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0]     LAST_WL  = CW'(WL_CYCLES - 1);
  localparam logic [CW-1:0]     LAST_REC = CW'(REC_CYCLES - 1);
  localparam logic [ADDR_W:0]   ROWS_LIM = (ADDR_W+1)'(ROWS);
  localparam logic [ROWS-1:0]   WL_ONE   = {{(ROWS-1){1'b0}}, 1'b1};

  logic [2:0]        state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [COLS-1:0]   lat_wdata;
  logic              accept, in_range;

  logic              ready_q, pre_q, bde_q, sense_q, done_q, err_q;
  logic [ROWS-1:0]   wl_q;
  logic [COLS-1:0]   bl_q, blb_q;

  logic              ready_d, pre_d, bde_d, sense_d, done_d, err_d;
  logic [ROWS-1:0]   wl_d;
  logic [COLS-1:0]   bl_d, blb_d;

  assign accept   = bus.req_valid && ready_q && (state == S_IDLE);
  assign in_range = ({1'b0, lat_addr} < ROWS_LIM);

  // Phase sequencing; the counter restarts at zero on every state entry.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + {{(CW-1){1'b0}}, 1'b1};
    case (state)
      S_IDLE: begin
        cnt_next = {CW{1'b0}};
        if (accept) state_next = S_PRE;
        else        state_next = S_IDLE;
      end
      S_PRE: begin
        if (cnt == LAST_PRE) begin
          state_next = S_ACT;
          cnt_next   = {CW{1'b0}};
        end else begin
          state_next = S_PRE;
        end
      end
      S_ACT: begin
        if (cnt == LAST_WL) begin
          state_next = S_REC;
          cnt_next   = {CW{1'b0}};
        end else begin
          state_next = S_ACT;
        end
      end
      S_REC: begin
        if (cnt == LAST_REC) begin
          state_next = S_DONE;
          cnt_next   = {CW{1'b0}};
        end else begin
          state_next = S_REC;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        cnt_next   = {CW{1'b0}};
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = {CW{1'b0}};
      end
    endcase
  end

  // State, phase counter and the request captured at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= {CW{1'b0}};
      lat_we    <= 1'b0;
      lat_addr  <= {ADDR_W{1'b0}};
      lat_wdata <= {COLS{1'b0}};
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end else begin
        lat_we    <= lat_we;
        lat_addr  <= lat_addr;
        lat_wdata <= lat_wdata;
      end
    end
  end

  // Array drive decode; an out-of-range row runs the timing with every strobe suppressed.
  always_comb begin
    ready_d = (state_next == S_IDLE);
    pre_d   = 1'b0;
    bde_d   = 1'b0;
    sense_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wl_d    = {ROWS{1'b0}};
    bl_d    = {COLS{1'b0}};
    blb_d   = {COLS{1'b0}};
    case (state)
      S_PRE: pre_d = 1'b1;
      S_ACT: begin
        if (in_range) begin
          wl_d = WL_ONE << lat_addr;
          if (lat_we) begin
            bde_d = 1'b1;
            bl_d  = lat_wdata;
            blb_d = ~lat_wdata;
          end else begin
            sense_d = (cnt == LAST_WL);
          end
        end else begin
          wl_d = {ROWS{1'b0}};
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        err_d  = ~in_range;
      end
      default: begin
        pre_d = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b1;
      pre_q   <= 1'b0;
      bde_q   <= 1'b0;
      sense_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wl_q    <= {ROWS{1'b0}};
      bl_q    <= {COLS{1'b0}};
      blb_q   <= {COLS{1'b0}};
    end else begin
      ready_q <= ready_d;
      pre_q   <= pre_d;
      bde_q   <= bde_d;
      sense_q <= sense_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wl_q    <= wl_d;
      bl_q    <= bl_d;
      blb_q   <= blb_d;
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.precharge_en = pre_q;
  assign bus.wl           = wl_q;
  assign bus.bl_drive_en  = bde_q;
  assign bus.bl           = bl_q;
  assign bus.blb          = blb_q;
  assign bus.sense_en     = sense_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_sram_access_sequencer.sv
// Scoreboard bench: each accepted request queues its expected per-cycle output vectors.
// Instance a uses defaults; instance b uses ROWS=12 and single-cycle phases.
module tb_sram_access_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_access_sequencer_if #(.ROWS(16), .ADDR_W(4), .COLS(8)) ia ();
  sram_access_sequencer_if #(.ROWS(12), .ADDR_W(4), .COLS(8)) ib ();

  sram_access_sequencer #(.ROWS(16), .ADDR_W(4), .COLS(8),
    .PRE_CYCLES(2), .WL_CYCLES(3), .REC_CYCLES(1)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  sram_access_sequencer #(.ROWS(12), .ADDR_W(4), .COLS(8),
    .PRE_CYCLES(1), .WL_CYCLES(1), .REC_CYCLES(1)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] ea, eb;
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // {ready, precharge, bl_drive, sense, done, err, wl[15:0], bl, blb}
  function automatic logic [63:0] pk(input logic rdy, input logic pre, input logic bde,
                                     input logic sen, input logic dn, input logic er,
                                     input logic [15:0] w, input logic [7:0] b, input logic [7:0] bb);
    return {26'd0, rdy, pre, bde, sen, dn, er, w, b, bb};
  endfunction

  function automatic logic [63:0] snap_a();
    return pk(ia.req_ready, ia.precharge_en, ia.bl_drive_en, ia.sense_en, ia.done, ia.err,
              ia.wl, ia.bl, ia.blb);
  endfunction

  function automatic logic [63:0] snap_b();
    return pk(ib.req_ready, ib.precharge_en, ib.bl_drive_en, ib.sense_en, ib.done, ib.err,
              16'(ib.wl), ib.bl, ib.blb);
  endfunction

  function automatic logic [63:0] idle_vec();
    return pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 8'd0);
  endfunction

  function automatic void put(input int which, input logic [63:0] v);
    if (which == 0) qa.push_back(v);
    else            qb.push_back(v);
  endfunction

  // Expected outputs: one idle-not-ready cycle, then PRE, ACT, REC phases, then DONE.
  function automatic void push_seq(input int which, input logic we, input logic [3:0] addr,
                                   input logic [7:0] wd, input int p, input int w, input int r,
                                   input int rows);
    logic        in_r;
    logic [15:0] one;
    logic [15:0] wlv;
    in_r = (int'(addr) < rows);
    one  = 16'd1;
    wlv  = in_r ? (one << addr) : 16'd0;
    put(which, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 8'd0));
    for (int i = 0; i < p; i++)
      put(which, pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 8'd0));
    for (int i = 0; i < w; i++)
      put(which, pk(1'b0, 1'b0, we & in_r, (!we) && in_r && (i == w - 1), 1'b0, 1'b0, wlv,
                    (we && in_r) ? wd : 8'd0, (we && in_r) ? ~wd : 8'd0));
    for (int i = 0; i < r; i++)
      put(which, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 8'd0));
    put(which, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, !in_r, 16'd0, 8'd0, 8'd0));
  endfunction

  // Acceptance model: a valid request is taken whenever the previous access has fully drained.
  always @(posedge clk) begin
    if (!rst) begin
      if (ia.req_valid && qa.size() == 0)
        push_seq(0, ia.req_we, ia.req_addr, ia.req_wdata, 2, 3, 1, 16);
      if (ib.req_valid && qb.size() == 0)
        push_seq(1, ib.req_we, ib.req_addr, ib.req_wdata, 1, 1, 1, 12);
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      ea = (qa.size() != 0) ? qa.pop_front() : idle_vec();
      eb = (qb.size() != 0) ? qb.pop_front() : idle_vec();
      check_eq("a_cycle", snap_a(), ea);
      check_eq("b_cycle", snap_b(), eb);
    end
  end

  task automatic issue(input int which, input logic we, input logic [3:0] addr,
                       input logic [7:0] wd, input int gap);
    @(negedge clk);
    if (which == 0) begin
      ia.req_valid = 1'b1; ia.req_we = we; ia.req_addr = addr; ia.req_wdata = wd;
    end else begin
      ib.req_valid = 1'b1; ib.req_we = we; ib.req_addr = addr; ib.req_wdata = wd;
    end
    @(negedge clk);
    ia.req_valid = 1'b0;
    ib.req_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ia.req_valid = 1'b0; ia.req_we = 1'b0; ia.req_addr = 4'd0; ia.req_wdata = 8'd0;
    ib.req_valid = 1'b0; ib.req_we = 1'b0; ib.req_addr = 4'd0; ib.req_wdata = 8'd0;
    #1;
    check_eq("reset_state_a", snap_a(), idle_vec());
    check_eq("reset_state_b", snap_b(), idle_vec());
    #11 rst = 1'b0;

    issue(0, 1'b1, 4'd5, 8'hA5, 10);
    issue(0, 1'b0, 4'd15, 8'h00, 10);
    issue(1, 1'b1, 4'd13, 8'hFF, 6);
    issue(1, 1'b1, 4'd3, 8'h3C, 6);
    issue(1, 1'b0, 4'd7, 8'h00, 6);
    issue(1, 1'b0, 4'd12, 8'h00, 6);
    issue(0, 1'b0, 4'd0, 8'h00, 10);

    // Continuous valid with a fresh address and data every cycle.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ia.req_valid = 1'b1;
      ia.req_we    = 1'($urandom_range(0, 1));
      ia.req_addr  = 4'($urandom_range(0, 15));
      ia.req_wdata = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    ia.req_valid = 1'b0;
    repeat (10) @(negedge clk);

    // Reset in the middle of the wordline phase of a write.
    issue(0, 1'b1, 4'd5, 8'hA5, 3);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_a", snap_a(), idle_vec());
    qa.delete();
    qb.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);

    issue(1, 1'b1, 4'd11, 8'h96, 6);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sram_access_sequencer.md
Name: sram_access_sequencer

Overview:
- Parametrised, clocked successor to the combinational wordline/bitline drivers.
- Accepts one read or write request at a time and sequences the SRAM array phases: bitline precharge, then a wordline pulse (with differential bitline drive on writes, or a sense enable on reads), then recovery.
- Sits between the controller front end and the row decoder, wordline drivers and write drivers.
- All phase widths are set by parameters.

Parameters:
- ROWS, 16, number of wordlines; legal range 2..2**ADDR_W.
- ADDR_W, 4, row address width.
- COLS, 8, data width; equals the number of bitline pairs.
- PRE_CYCLES, 2, precharge phase length in cycles; must be ≥1.
- WL_CYCLES, 3, wordline-active phase length in cycles; must be ≥1.
- REC_CYCLES, 1, recovery phase length in cycles; must be ≥1.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  row address.
- req_wdata  input  COLS  write data.
- precharge_en  output  1  bitline precharge enable.
- wl  output  ROWS  one-hot wordline enables.
- bl_drive_en  output  1  write-driver enable.
- bl  output  COLS  true bitline drive value.
- blb  output  COLS  complement bitline drive value.
- sense_en  output  1  sense-amp strobe.
- done  output  1  one-cycle completion pulse.
- err  output  1  error flag for the completed request; valid only while done=1.

Behaviour:
- Interface
  - One clock (clk); reset is asynchronous and active-high (rst).
  - All outputs are registered.
- Reset
  - rst=1 forces, immediately and asynchronously: state=IDLE, phase counter=0, req_ready=1, all other outputs 0, latched request cleared.
  - Reset asserted mid-sequence aborts the access; no done pulse follows.
- States
  - IDLE
  - PRE: PRE_CYCLES cycles.
  - ACT: WL_CYCLES cycles.
  - REC: REC_CYCLES cycles.
  - DONE: 1 cycle.
  - After DONE the block returns to IDLE.
- Handshake
  - req_ready=1 only in IDLE.
  - A request is accepted on a rising edge with req_valid & req_ready.
  - On acceptance, req_we, req_addr and req_wdata are latched and the state goes to PRE on that edge.
  - Request inputs are ignored outside IDLE.
  - req_ready is 0 in the DONE cycle, so there is no back-to-back acceptance; minimum spacing between acceptances is PRE+WL+REC+2 cycles.
- Phase counter
  - Width is clog2 of the largest phase parameter, plus 1.
  - Loaded to 0 on each state entry.
  - The state advances when counter == phase length − 1.
- PRE
  - precharge_en=1; wl=0; bl_drive_en=0.
- ACT
  - precharge_en=0.
  - wl[addr]=1 if addr < ROWS; otherwise wl=0.
  - Write: bl_drive_en=1, bl=wdata, blb=~wdata.
  - Read: bl_drive_en=0, bl=blb=0; sense_en=1 in the final ACT cycle only.
- REC
  - All enables 0; bl=blb=0.
- DONE
  - done=1 for exactly one cycle.
  - err=1 if the latched addr ≥ ROWS; otherwise err=0.
- Out-of-range address
  - The full timing still runs.
  - No wordline fires, no bitline drive, no sense strobe.
- Latency
  - Request accepted at edge E → done high in the cycle after edge E + PRE + WL + REC.
  - With defaults: accept at edge E, done registered at edge E+7, high during that cycle.
- Invariants
  - At most one wl bit is high at any time.
  - precharge_en and wl are never high together.
  - bl_drive_en and sense_en are never high together.
  - bl and blb are never both 1.

Test Plan:
- Reset
  - Assert rst mid-ACT of a write to addr 5.
  - Required: wl, bl_drive_en, bl, blb go to 0 without waiting for a clock edge.
  - Required: req_ready=1 and done=0 after release; no done pulse follows.
- Write, defaults
  - Write addr=5, wdata=0xA5.
  - Required: precharge_en high 2 cycles; then wl=0x0020 and bl=0xA5, blb=0x5A, bl_drive_en=1 for 3 cycles.
  - Required: 1 recovery cycle, then done=1, err=0.
- Read
  - Read addr=15.
  - Required: wl=0x8000 for 3 cycles; sense_en=1 only in the 3rd of those cycles; bl_drive_en=0 throughout.
  - Required: done on the 7th edge after acceptance.
- Out-of-range, ROWS=12
  - Write addr=13.
  - Required: wl stays 0, bl_drive_en stays 0; done=1 with err=1 at the standard latency.
- Handshake
  - Hold req_valid=1 continuously with changing addr.
  - Required: acceptances spaced 8 cycles apart; each access uses the addr present at its own acceptance edge.
- Timing parameters, PRE=1, WL=1, REC=1
  - Issue one write and one read.
  - Required: each phase lasts exactly 1 cycle; sense_en coincides with the single ACT cycle; done at edge E+4.
